// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the sizing function for the shared delay counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter must hold the larger of the two delays; the +1 keeps a single-cycle
  // delay at a legal one-bit width.
  function automatic int cnt_width(input int min_hold, input int stage_dly);
    int m;
    m = (min_hold > stage_dly) ? min_hold : stage_dly;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software-facing side of the reset sequencer: re-reset request, sequenced
// reset outputs, completion flag and the FSM state for observation.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 3
);
  import rst_seq_pkg::*;

  // sw_rst_req is a level request with no acknowledge: every posedge that sees
  // it high (once the raw reset is synchronised out) re-asserts all outputs and
  // restarts the release sequence; there is no valid/ready pairing.
  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_n;
  logic               rst_done;
  state_t             state;

  modport master (
    output sw_rst_req,
    input  rst_n,
    input  rst_done,
    input  state
  );

  modport slave (
    input  sw_rst_req,
    output rst_n,
    output rst_done,
    output state
  );

endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Reset synchroniser: asserts asynchronously with RST_n, releases after STAGES
// clk edges through a chain whose input is tied high.
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic RST_n,
  output logic sync_n
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: synchronises the raw reset, then releases NUM_OUT
// active-low resets one at a time in index order with programmable spacing.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int MIN_HOLD    = 4,
  parameter int STAGE_DLY   = 8
) (
  input  logic              clk,
  input  logic              RST_n,
  reset_sequencer_if.slave  bus
);

  localparam int CW    = cnt_width(MIN_HOLD, STAGE_DLY);
  localparam int IDX_W = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0]    HOLD_LAST  = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0]    STAGE_LAST = CW'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

  logic               sync_n;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OUT-1:0] rst_q;
  logic               done_q;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .RST_n  (RST_n),
    .sync_n (sync_n)
  );

  // Releasing a bit shifts a one in from the bottom, so the outputs can only
  // ever form a contiguous prefix of released bits starting at index 0.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else if (!sync_n || bus.sw_rst_req) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            rst_q <= (rst_q << 1) | NUM_OUT'(1);
            if (NUM_OUT > 1) begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        RELEASE: begin
          if (cnt == STAGE_LAST) begin
            cnt   <= '0;
            rst_q <= (rst_q << 1) | NUM_OUT'(1);
            if (idx == IDX_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= HOLD;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  assign bus.rst_n    = rst_q;
  assign bus.rst_done = done_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default-parameter instance plus a
// SYNC_STAGES=3 / NUM_OUT=1 / MIN_HOLD=1 instance sharing the raw reset.
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  logic clk;
  logic RST_n;
  int   checks;
  int   errors;
  int   cur_off;

  reset_sequencer_if #(.NUM_OUT(3)) b1 ();
  reset_sequencer_if #(.NUM_OUT(1)) b2 ();

  reset_sequencer #(
    .SYNC_STAGES (2),
    .NUM_OUT     (3),
    .MIN_HOLD    (4),
    .STAGE_DLY   (8)
  ) dut (
    .clk   (clk),
    .RST_n (RST_n),
    .bus   (b1.slave)
  );

  reset_sequencer #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .MIN_HOLD    (1),
    .STAGE_DLY   (8)
  ) dut2 (
    .clk   (clk),
    .RST_n (RST_n),
    .bus   (b2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected-value table: grp 0 = offsets from the edge before E1 after a raw
  // reset release, grp 1 = offsets from the last edge sampling sw_rst_req high
  typedef struct {
    int         grp;
    int         off;
    logic [2:0] r;
    logic       d;
    logic       r2;
    logic       d2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input int g, input int o, input logic [2:0] r,
                              input logic d, input logic r2, input logic d2);
    vec_t v;
    v.grp = g; v.off = o; v.r = r; v.d = d; v.r2 = r2; v.d2 = d2;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur_off++;
  endtask

  task automatic run_group(input int g);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].grp == g) begin
        while (cur_off < vecs[i].off) step();
        check($sformatf("g%0d_off%0d_rst_n", g, vecs[i].off), {5'b0, b1.rst_n}, {5'b0, vecs[i].r});
        check($sformatf("g%0d_off%0d_done", g, vecs[i].off), {7'b0, b1.rst_done}, {7'b0, vecs[i].d});
        check($sformatf("g%0d_off%0d_rst_n2", g, vecs[i].off), {7'b0, b2.rst_n}, {7'b0, vecs[i].r2});
        check($sformatf("g%0d_off%0d_done2", g, vecs[i].off), {7'b0, b2.rst_done}, {7'b0, vecs[i].d2});
      end
    end
  endtask

  task automatic check_all_low(input string name);
    check({name, "_rst_n"}, {5'b0, b1.rst_n}, 8'h00);
    check({name, "_done"}, {7'b0, b1.rst_done}, 8'h00);
    check({name, "_rst_n2"}, {7'b0, b2.rst_n}, 8'h00);
    check({name, "_done2"}, {7'b0, b2.rst_done}, 8'h00);
  endtask

  // ordering invariant: released bits form a prefix, done tracks the last bit
  always @(negedge clk) begin
    if (RST_n === 1'b1 || RST_n === 1'b0) begin
      checks++;
      if ((b1.rst_n[2] && !b1.rst_n[1]) || (b1.rst_n[1] && !b1.rst_n[0]) ||
          (b1.rst_done !== b1.rst_n[2]) || (b2.rst_done !== b2.rst_n[0])) begin
        errors++;
        $display("FAIL prefix_invariant: rst_n=%b done=%b rst_n2=%b done2=%b at t=%0t",
                 b1.rst_n, b1.rst_done, b2.rst_n, b2.rst_done, $time);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cur_off = 0;

    vecs[0]  = mk(0,  1, 3'b000, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(0,  2, 3'b000, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(0,  3, 3'b000, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(0,  4, 3'b000, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mk(0,  5, 3'b000, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mk(0,  6, 3'b001, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(0, 13, 3'b001, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(0, 14, 3'b011, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(0, 21, 3'b011, 1'b0, 1'b1, 1'b1);
    vecs[9]  = mk(0, 22, 3'b111, 1'b1, 1'b1, 1'b1);
    vecs[10] = mk(1,  0, 3'b000, 1'b0, 1'b1, 1'b1);
    vecs[11] = mk(1,  3, 3'b000, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk(1,  4, 3'b001, 1'b0, 1'b1, 1'b1);
    vecs[13] = mk(1, 11, 3'b001, 1'b0, 1'b1, 1'b1);
    vecs[14] = mk(1, 12, 3'b011, 1'b0, 1'b1, 1'b1);
    vecs[15] = mk(1, 19, 3'b011, 1'b0, 1'b1, 1'b1);
    vecs[16] = mk(1, 20, 3'b111, 1'b1, 1'b1, 1'b1);

    // power-on: raw reset low for 5 cycles, released between edges
    b1.sw_rst_req = 1'b0;
    b2.sw_rst_req = 1'b0;
    RST_n = 1'b1;
    #1 RST_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_all_low("por_low");
    end
    check("por_state", {6'b0, b1.state}, {6'b0, HOLD});
    @(negedge clk);
    RST_n = 1'b1;
    cur_off = 0;
    run_group(0);

    // 2 ns raw reset pulse after completion: outputs drop before any clk edge
    @(negedge clk);
    RST_n = 1'b0;
    #2;
    check_all_low("pulse_done_async");
    RST_n = 1'b1;
    cur_off = 0;
    run_group(0);

    // raw reset pulse at E10, between rst_n[0] and rst_n[1]
    @(negedge clk);
    RST_n = 1'b0;
    #1 RST_n = 1'b1;
    cur_off = 0;
    while (cur_off < 10) step();
    check("e10_rst_n", {5'b0, b1.rst_n}, 8'h01);
    RST_n = 1'b0;
    #1;
    check_all_low("e10_async");
    RST_n = 1'b1;
    cur_off = 0;
    run_group(0);

    // one-cycle software re-reset while in DONE
    @(negedge clk);
    b1.sw_rst_req = 1'b1;
    step();
    b1.sw_rst_req = 1'b0;
    cur_off = 0;
    run_group(1);

    // software re-reset held for 10 edges starting in RELEASE
    @(negedge clk);
    RST_n = 1'b0;
    #1 RST_n = 1'b1;
    cur_off = 0;
    while (cur_off < 8) step();
    check("hold_pre_rst_n", {5'b0, b1.rst_n}, 8'h01);
    check("hold_pre_state", {6'b0, b1.state}, {6'b0, RELEASE});
    @(negedge clk);
    b1.sw_rst_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("sw_hold_%0d_rst_n", i), {5'b0, b1.rst_n}, 8'h00);
      check($sformatf("sw_hold_%0d_state", i), {6'b0, b1.state}, {6'b0, HOLD});
    end
    b1.sw_rst_req = 1'b0;
    cur_off = 0;
    run_group(1);
    check("final_state", {6'b0, b1.state}, {6'b0, DONE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
